// File: rtl/fp_result_collector_if.sv
// Handshake and read-port bundle between the multiplier output wrapper, the
// result collector and its downstream consumer.
interface fp_result_collector_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          resultReady;
   logic [31:0]   OutBus;
   logic          resultAccepted;
   logic          rd_en;
   logic [31:0]   rd_data;
   logic          empty;
   logic          full;
   logic [CW-1:0] count;
   logic          is_zero;
   logic          is_inf;
   logic          is_nan;
   logic          is_denorm;
   logic          underflow_err;
   logic [7:0]    total_results;

   modport master (
      output resultReady, OutBus, rd_en,
      input  resultAccepted, rd_data, empty, full, count,
             is_zero, is_inf, is_nan, is_denorm, underflow_err, total_results
   );

   modport slave (
      input  resultReady, OutBus, rd_en,
      output resultAccepted, rd_data, empty, full, count,
             is_zero, is_inf, is_nan, is_denorm, underflow_err, total_results
   );
endinterface

// File: rtl/fp_result_collector.sv
// Captures multiplier products through a four-phase handshake into a show-ahead
// FIFO and classifies the head entry as zero / inf / NaN / denormal.
module fp_result_collector #(
   parameter int DEPTH = 4
) (
   input logic                 clk,
   input logic                 rst,
   fp_result_collector_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {IDLE, ACK} state_t;

   state_t        stateReg;
   logic          ackReg;
   logic [31:0]   memArray [DEPTH];
   logic [AW-1:0] headPtrReg;
   logic [AW-1:0] tailPtrReg;
   logic [CW-1:0] countReg;
   logic [CW-1:0] countNext;
   logic [31:0]   rdDataReg;
   logic [31:0]   rdDataNext;
   logic          underflowReg;
   logic [7:0]    totalReg;

   logic          emptyNow;
   logic          fullNow;
   logic          capture;
   logic          pop;
   logic [AW-1:0] headPlusOne;

   assign emptyNow    = (countReg == '0);
   assign fullNow     = (countReg == CW'(DEPTH));
   assign capture     = (stateReg == IDLE) && bus.resultReady && !fullNow;
   assign pop         = bus.rd_en && !emptyNow;
   assign headPlusOne = headPtrReg + AW'(1);

   always_comb begin
      countNext = countReg;
      if (capture && !pop)
         countNext = countReg + CW'(1);
      else if (pop && !capture)
         countNext = countReg - CW'(1);
   end

   // Head register tracks what the array head will be after this edge; a
   // product written into an empty (or just-emptied) FIFO bypasses the array.
   always_comb begin
      rdDataNext = rdDataReg;
      if (countNext == '0)
         rdDataNext = '0;
      else if (emptyNow || (pop && countReg == CW'(1)))
         rdDataNext = bus.OutBus;
      else if (pop)
         rdDataNext = memArray[headPlusOne];
   end

   always_ff @(posedge clk) begin
      if (capture)
         memArray[tailPtrReg] <= bus.OutBus;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stateReg     <= IDLE;
         ackReg       <= 1'b0;
         headPtrReg   <= '0;
         tailPtrReg   <= '0;
         countReg     <= '0;
         rdDataReg    <= '0;
         underflowReg <= 1'b0;
         totalReg     <= '0;
      end else begin
         case (stateReg)
            IDLE: begin
               if (capture) begin
                  stateReg <= ACK;
                  ackReg   <= 1'b1;
               end
            end
            ACK: begin
               if (!bus.resultReady) begin
                  stateReg <= IDLE;
                  ackReg   <= 1'b0;
               end
            end
            default: begin
               stateReg <= IDLE;
               ackReg   <= 1'b0;
            end
         endcase

         if (capture) begin
            tailPtrReg <= tailPtrReg + AW'(1);
            totalReg   <= totalReg + 8'd1;
         end
         if (pop)
            headPtrReg <= headPlusOne;
         if (bus.rd_en && emptyNow)
            underflowReg <= 1'b1;

         countReg  <= countNext;
         rdDataReg <= rdDataNext;
      end
   end

   logic [7:0]  expField;
   logic [22:0] fracField;

   assign expField  = rdDataReg[30:23];
   assign fracField = rdDataReg[22:0];

   always_comb begin
      bus.is_zero   = 1'b0;
      bus.is_denorm = 1'b0;
      bus.is_inf    = 1'b0;
      bus.is_nan    = 1'b0;
      if (!emptyNow) begin
         bus.is_zero   = (expField == 8'h00) && (fracField == '0);
         bus.is_denorm = (expField == 8'h00) && (fracField != '0);
         bus.is_inf    = (expField == 8'hFF) && (fracField == '0);
         bus.is_nan    = (expField == 8'hFF) && (fracField != '0);
      end
   end

   assign bus.resultAccepted = ackReg;
   assign bus.rd_data        = rdDataReg;
   assign bus.empty          = emptyNow;
   assign bus.full           = fullNow;
   assign bus.count          = countReg;
   assign bus.underflow_err  = underflowReg;
   assign bus.total_results  = totalReg;
endmodule

// File: tb/tb_fp_result_collector.sv
// Randomised bench for fp_result_collector: a queue-based reference model is
// compared every cycle, and a scoreboard checks popped data in issue order.
module tb_fp_result_collector;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fp_result_collector_if #(.DEPTH(DEPTH)) bus ();

   fp_result_collector #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int passes = 0;

   logic [31:0] expQ[$];     // products in the order the producer issued them
   logic [31:0] modelQ[$];   // what the collector should currently hold
   bit          modelAck   = 1'b0;
   int          modelTotal = 0;
   bit          modelUnder = 1'b0;
   bit          rdAuto     = 1'b0;
   int          rdPct      = 50;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req)
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      else
         passes++;
   endfunction

   function automatic void timeoutFail(string name);
      checks++;
      $display("FAIL %s: timed out at %0t", name, $time);
   endfunction

   // {zero, inf, nan, denorm} straight from the IEEE-754 field rules
   function automatic logic [3:0] classify(logic [31:0] v);
      logic [7:0]  e;
      logic [22:0] f;
      e = v[30:23];
      f = v[22:0];
      return {e == 0 && f == 0, e == 255 && f == 0, e == 255 && f != 0, e == 0 && f != 0};
   endfunction

   // Reference model: advances on each rising edge, compares 1 ns later.
   initial begin
      bit          cap, popNow;
      logic [31:0] head;
      logic [3:0]  cls;
      forever begin
         @(posedge clk);
         if (rst) begin
            modelQ.delete();
            modelAck   = 1'b0;
            modelTotal = 0;
            modelUnder = 1'b0;
         end else begin
            popNow = bus.rd_en && modelQ.size() > 0;
            cap    = !modelAck && bus.resultReady && modelQ.size() < DEPTH;
            if (bus.rd_en && modelQ.size() == 0) modelUnder = 1'b1;
            if (popNow) void'(modelQ.pop_front());
            if (cap) begin
               modelQ.push_back(bus.OutBus);
               modelTotal = (modelTotal + 1) % 256;
            end
            modelAck = modelAck ? bus.resultReady : cap;
         end
         #1;
         head = (modelQ.size() > 0) ? modelQ[0] : 32'h0;
         cls  = (modelQ.size() > 0) ? classify(head) : 4'b0;
         chk("resultAccepted", {31'b0, bus.resultAccepted}, {31'b0, modelAck});
         chk("count", 32'(bus.count), 32'(modelQ.size()));
         chk("empty", {31'b0, bus.empty}, {31'b0, modelQ.size() == 0});
         chk("full", {31'b0, bus.full}, {31'b0, modelQ.size() == DEPTH});
         chk("rd_data", bus.rd_data, head);
         chk("class_flags", {28'b0, bus.is_zero, bus.is_inf, bus.is_nan, bus.is_denorm},
             {28'b0, cls});
         chk("underflow_err", {31'b0, bus.underflow_err}, {31'b0, modelUnder});
         chk("total_results", {24'b0, bus.total_results}, 32'(modelTotal));
      end
   end

   // Scoreboard monitor: every real pop must deliver the oldest issued product.
   always @(negedge clk) begin
      if (!rst && bus.rd_en === 1'b1 && bus.empty === 1'b0) begin
         if (expQ.size() == 0)
            timeoutFail("pop_without_expected");
         else
            chk("pop_data", bus.rd_data, expQ.pop_front());
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rdAuto) bus.rd_en = ($urandom % 100) < rdPct;
      end
   end

   task automatic cyc(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic produce(logic [31:0] v, int hold);
      int n;
      bus.OutBus      = v;
      bus.resultReady = 1'b1;
      expQ.push_back(v);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!bus.resultAccepted && n < 300);
      if (!bus.resultAccepted) timeoutFail("accept_wait");
      cyc(hold);
      bus.resultReady = 1'b0;
      n = 0;
      do begin
         cyc();
         n++;
      end while (bus.resultAccepted && n < 10);
      if (bus.resultAccepted) timeoutFail("release_wait");
   endtask

   function automatic logic [31:0] randValue();
      logic [31:0] r;
      r = $urandom;
      case ($urandom % 6)
         0:       return {r[31], 31'h0};
         1:       return {r[31], 8'hFF, 23'h0};
         2:       return {r[31], 8'hFF, r[22:1], 1'b1};
         3:       return {r[31], 8'h00, r[22:1], 1'b1};
         default: return r;
      endcase
   endfunction

   initial begin
      bus.resultReady = 1'b0;
      bus.OutBus      = 32'h0;
      bus.rd_en       = 1'b0;
      cyc(3);
      rst = 1'b0;
      cyc();

      // single capture, request held three cycles
      produce(32'h40000000, 2);
      cyc();
      bus.rd_en = 1'b1;
      cyc();
      bus.rd_en = 1'b0;

      // fill to DEPTH, fifth product stalls until one pop
      for (int i = 0; i < DEPTH; i++) produce(32'h3F800000 + 32'(i << 20), 0);
      fork
         produce(32'h41000000, 0);
         begin
            cyc(5);
            bus.rd_en = 1'b1;
            cyc();
            bus.rd_en = 1'b0;
         end
      join
      // drain past empty so underflow_err latches
      bus.rd_en = 1'b1;
      cyc(DEPTH + 3);
      bus.rd_en = 1'b0;
      produce(32'h3F000000, 0);
      cyc(2);

      // simultaneous capture and pop at count 2
      rst = 1'b1;
      expQ.delete();
      cyc();
      rst = 1'b0;
      produce(32'h40400000, 0);
      produce(32'h40A00000, 0);
      bus.OutBus      = 32'h40800000;
      bus.resultReady = 1'b1;
      bus.rd_en       = 1'b1;
      expQ.push_back(32'h40800000);
      cyc();
      bus.rd_en       = 1'b0;
      bus.resultReady = 1'b0;
      cyc(2);
      bus.rd_en = 1'b1;
      cyc(2);
      bus.rd_en = 1'b0;

      // classification of special values at the head
      produce(32'h00000000, 0);
      produce(32'h7F800000, 0);
      produce(32'h7FC00000, 0);
      produce(32'h00000001, 0);
      for (int i = 0; i < 4; i++) begin
         bus.rd_en = 1'b1;
         cyc();
         bus.rd_en = 1'b0;
         cyc();
      end

      // reset while in ACK with two entries stored; request stays high
      produce(32'h40E00000, 0);
      produce(32'hC0000000, 0);
      bus.OutBus      = 32'h41200000;
      bus.resultReady = 1'b1;
      expQ.push_back(32'h41200000);
      cyc(2);
      rst = 1'b1;
      expQ.delete();
      expQ.push_back(32'h41200000);
      cyc();
      rst = 1'b0;
      cyc(2);
      bus.resultReady = 1'b0;
      cyc(2);
      bus.rd_en = 1'b1;
      cyc(2);
      bus.rd_en = 1'b0;

      // randomised traffic, long enough to wrap total_results
      rdAuto = 1'b1;
      for (int i = 0; i < 300; i++) begin
         rdPct = (i < 100) ? 15 : (i < 200) ? 60 : 90;
         produce(randValue(), int'($urandom_range(0, 3)));
         if ($urandom % 4 == 0) cyc(int'($urandom_range(1, 3)));
      end
      rdAuto = 1'b0;
      cyc();
      bus.rd_en = 1'b1;
      cyc(DEPTH + 2);
      bus.rd_en = 1'b0;
      cyc(2);
      chk("scoreboard_drained", 32'(expQ.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/fp_result_collector.md
FP_RESULT_COLLECTOR -- requirements
Module: fp_result_collector

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of result entries held; legal values are powers of two from 2 to 16.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous and active-high, sampled on the rising edge of clk.
REQ-004 resultReady  input  1  SHALL be the product-valid flag from the multiplier output wrapper, held high until acknowledged.
REQ-005 OutBus  input  32  SHALL be the IEEE-754 single-precision product, stable while resultReady=1.
REQ-006 resultAccepted  output  1  SHALL be the acknowledge returned to the output wrapper.
REQ-007 rd_en  input  1  SHALL be the pop request from the downstream consumer.
REQ-008 rd_data  output  32  SHALL be the head entry (show-ahead).
REQ-009 empty, full  output  1 each  SHALL be the FIFO status flags.
REQ-010 count  output  $clog2(DEPTH)+1  SHALL be the number of stored entries.
REQ-011 is_zero, is_inf, is_nan, is_denorm  output  1 each  SHALL classify rd_data.
REQ-012 underflow_err  output  1  SHALL be a sticky flag for a pop attempted while empty.
REQ-013 total_results  output  8  SHALL be the number of products captured since reset, modulo 256.

Function
REQ-014 The handshake FSM SHALL have exactly two states: IDLE and ACK.
REQ-015 In IDLE, when resultReady=1 and full=0 (registered value), the block SHALL write OutBus to the tail at that edge, increment total_results and enter ACK.
REQ-016 In IDLE, when resultReady=1 and full=1, the block SHALL stall: no write, resultAccepted=0, remain in IDLE.
REQ-017 resultAccepted SHALL be 1 exactly while in ACK (registered output).
REQ-018 In ACK, the block SHALL stay in ACK while resultReady=1 and SHALL return to IDLE on the edge where resultReady=0 (four-phase).
REQ-019 One resultReady assertion SHALL produce exactly one captured entry, however long resultReady stays high.
REQ-020 Capture latency SHALL be one cycle: resultReady seen at edge N means data is written and resultAccepted=1 after edge N; the product is visible on rd_data after edge N if the FIFO was empty.
REQ-021 A pop SHALL occur at an edge where rd_en=1 and empty=0; the head pointer SHALL advance and count SHALL decrement.
REQ-022 A simultaneous capture and pop with 0<count<DEPTH SHALL perform both, leaving count unchanged.
REQ-023 When full=1, rd_en=1 and resultReady=1 in the same cycle, the pop SHALL occur and the capture SHALL be deferred to the next cycle, per REQ-016.
REQ-024 When empty=1, rd_en=1 SHALL be ignored and underflow_err SHALL be set to 1, even if a capture occurs in the same cycle.
REQ-025 Pointers SHALL wrap modulo DEPTH; full=(count==DEPTH); empty=(count==0).
REQ-026 rd_data SHALL be 32'h0 when empty=1.
REQ-027 Classification SHALL be combinational from rd_data, using exp=rd_data[30:23] and frac=rd_data[22:0]:
  - is_zero: exp=0 and frac=0
  - is_denorm: exp=0 and frac!=0
  - is_inf: exp=255 and frac=0
  - is_nan: exp=255 and frac!=0
  - all four flags SHALL be 0 when empty=1.
REQ-028 total_results SHALL wrap from 255 to 0.

Reset
REQ-029 With rst=1 at an edge, the block SHALL produce: FSM=IDLE, resultAccepted=0, pointers=0, count=0, empty=1, full=0, rd_data=0, all class flags=0, underflow_err=0, total_results=0.
REQ-030 Reset SHALL take priority over every capture and pop in the same cycle.
REQ-031 Reset asserted while in ACK SHALL drop resultAccepted at that edge; a resultReady still high after reset SHALL be captured again as a new result.
REQ-032 Storage array contents need not be cleared; they SHALL never be observable while empty=1.

Verification
REQ-033 Single capture: OutBus=32'h40000000 (2.0*1.0), resultReady=1 held 3 cycles -> one entry, resultAccepted=1 until resultReady drops, rd_data=32'h40000000, count=1, total_results=1.
REQ-034 Fill and stall: capture 5 products with DEPTH=4 -> full=1 after 4; the 5th sees resultAccepted=0 until one rd_en pop, then is captured; output order is preserved.
REQ-035 Simultaneous capture and pop at count=2: OutBus=32'h40800000 with rd_en=1 -> count stays 2, and the old head is replaced by the next entry.
REQ-036 Underflow: rd_en=1 while empty -> underflow_err=1 and stays 1 through later traffic until rst.
REQ-037 Classification: push 32'h00000000, 32'h7F800000, 32'h7FC00000, 32'h00000001 -> the head flags read is_zero, is_inf, is_nan, is_denorm in that order.
REQ-038 Reset mid-handshake: rst pulse while in ACK with 2 entries stored -> all outputs match REQ-029, then the still-high resultReady is captured at the next edge.
